// File: rtl/conv_pixel_scheduler.sv
// Convolution layer pass sequencer: walks groups/rows/cols and per-pixel input-map/kernel cycles,
// issuing memory reads and MAC control with a stall-aware start/clear/run/drain/done FSM.
module conv_pixel_scheduler #(
   parameter int NUM_MEM       = 6,
   parameter int KERNEL_CYCLES = 25,
   parameter int OUT_WIDTH     = 10,
   parameter int NUM_GROUPS    = 16,
   parameter int PIPE_LAT      = 3,
   parameter int CPP_W         = 8,
   parameter int SEL_W         = 4,
   parameter int POS_W         = 4,
   parameter int GRP_W         = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             mem_rden,
   output logic [SEL_W-1:0] mem_sel,
   output logic             accum_sload,
   output logic             mult_en,
   output logic             mult_clear,
   output logic             pixel_valid,
   output logic [POS_W-1:0] out_row,
   output logic [POS_W-1:0] out_col,
   output logic [GRP_W-1:0] group_idx
);

   localparam int                CPP      = NUM_MEM * KERNEL_CYCLES;
   localparam logic [CPP_W-1:0]  K_LAST   = CPP_W'(CPP - 1);
   localparam logic [CPP_W-1:0]  KC_LAST  = CPP_W'(KERNEL_CYCLES - 1);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_WIDTH - 1);
   localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(NUM_GROUPS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             vld;
      logic             first;
      logic             last;
      logic [GRP_W-1:0] grp;
      logic [POS_W-1:0] row;
      logic [POS_W-1:0] col;
   } mark_t;

   state_t state_q, state_d;

   logic [CPP_W-1:0] k_q, kc_q;
   logic [SEL_W-1:0] sel_q;
   logic [POS_W-1:0] row_q, col_q;
   logic [GRP_W-1:0] grp_q;

   // Index 0 is the newest issue; index PIPE_LAT-1 is MAC arrival, PIPE_LAT is result out.
   mark_t [PIPE_LAT:0] pipe_q;
   mark_t              issue_mark;

   logic active, frozen, issue, k_wrap, final_issue, pending;

   assign active      = (state_q == RUN) || (state_q == DRAIN);
   assign frozen      = active && stall;
   assign issue       = (state_q == RUN) && !stall;
   assign k_wrap      = (k_q == K_LAST);
   assign final_issue = issue && k_wrap && (col_q == POS_LAST) &&
                        (row_q == POS_LAST) && (grp_q == GRP_LAST);

   always_comb begin
      issue_mark       = '0;
      issue_mark.vld   = issue;
      issue_mark.first = issue && (k_q == '0);
      issue_mark.last  = issue && k_wrap;
      issue_mark.grp   = grp_q;
      issue_mark.row   = row_q;
      issue_mark.col   = col_q;
   end

   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) pending = pending | pipe_q[i].vld;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k_q   <= '0;
         kc_q  <= '0;
         sel_q <= '0;
         row_q <= '0;
         col_q <= '0;
         grp_q <= '0;
      end else if (state_q == CLEAR) begin
         k_q   <= '0;
         kc_q  <= '0;
         sel_q <= '0;
         row_q <= '0;
         col_q <= '0;
         grp_q <= '0;
      end else if (issue) begin
         // mem_sel tracks k / KERNEL_CYCLES through its own kernel sub-counter.
         if (kc_q == KC_LAST) begin
            kc_q  <= '0;
            sel_q <= k_wrap ? '0 : sel_q + SEL_W'(1);
         end else begin
            kc_q <= kc_q + CPP_W'(1);
         end

         if (k_wrap) begin
            k_q <= '0;
            if (col_q == POS_LAST) begin
               col_q <= '0;
               if (row_q == POS_LAST) begin
                  row_q <= '0;
                  grp_q <= (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
               end else begin
                  row_q <= row_q + POS_W'(1);
               end
            end else begin
               col_q <= col_q + POS_W'(1);
            end
         end else begin
            k_q <= k_q + CPP_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)        pipe_q <= '0;
      else if (!frozen) pipe_q <= {pipe_q[PIPE_LAT-1:0], issue_mark};
   end

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (go) state_d = CLEAR;
         CLEAR:   state_d = RUN;
         RUN:     if (final_issue) state_d = DRAIN;
         DRAIN:   if (!stall && pipe_q[PIPE_LAT].last && !pending) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == CLEAR) || active;
      done        = (state_q == DONE);
      mult_clear  = (state_q == CLEAR);
      mult_en     = (state_q == CLEAR) || (active && !stall);
      mem_rden    = issue;
      accum_sload = active && !stall && pipe_q[PIPE_LAT-1].first;
      pixel_valid = active && !stall && pipe_q[PIPE_LAT].last;
      out_row     = pipe_q[PIPE_LAT].row;
      out_col     = pipe_q[PIPE_LAT].col;
      group_idx   = pipe_q[PIPE_LAT].grp;
   end

   assign mem_sel = sel_q;

endmodule

// File: doc/conv_pixel_scheduler.md
Name: conv_pixel_scheduler

Overview:
- Sequences one convolution layer pass on the shared multiplier/accumulator datapath.
- Walks output groups, rows, columns and the per-pixel input-map/kernel cycles.
- Drives input-memory bank select and read enables, accumulator sload, and multiplier enable/clear.
- Sits between the layer-level top controller (go/done handshake) and the per-layer mux/MAC datapath. It replaces free-running enable-driven counting with an explicit start/stall/done FSM.

Parameters:
- NUM_MEM, 6, number of input feature memories (input maps) walked per output pixel
- KERNEL_CYCLES, 25, accumulate cycles spent on each input memory per pixel
- OUT_WIDTH, 10, output feature map width = height
- NUM_GROUPS, 16, output map groups processed sequentially by the one MAC array
- PIPE_LAT, 3, cycles from issue (read enable) to operand arrival at the MAC, ≥1
- CPP_W, 8, width of per-pixel cycle counter, ≥ clog2(NUM_MEM*KERNEL_CYCLES)
- SEL_W, 4, width of mem_sel, ≥ clog2(NUM_MEM)
- POS_W, 4, width of out_row/out_col
- GRP_W, 4, width of group_idx

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- go  in  1  start request; sampled only in IDLE
- stall  in  1  freeze request from downstream
- busy  out  1  high from the cycle after accepted go until done
- done  out  1  one-cycle pulse at layer completion
- mem_rden  out  1  read enable to all input memories
- mem_sel  out  SEL_W  input memory index for the datapath mux (issue-aligned)
- accum_sload  out  1  accumulator load (restart) strobe, MAC-aligned
- mult_en  out  1  multiplier/accumulator clock enable
- mult_clear  out  1  synchronous clear of MAC array
- pixel_valid  out  1  accumulated pixel result valid, one cycle
- out_row, out_col  out  POS_W each  coordinates of the pixel flagged by pixel_valid
- group_idx  out  GRP_W  group of the pixel flagged by pixel_valid

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters and pipeline marks 0. Reset mid-operation aborts immediately with no done pulse.
- CPP = NUM_MEM*KERNEL_CYCLES. The issue counter k runs 0..CPP-1. mem_sel = k / KERNEL_CYCLES, computed by a separate sub-counter (no divider).
- IDLE -> CLEAR when go=1. go is ignored when not in IDLE.
- CLEAR lasts exactly 1 cycle: mult_clear=1 and busy=1.
- CLEAR -> RUN.
- RUN: mem_rden=1 and k increments each unstalled cycle.
  - When k=CPP-1, k wraps to 0 and col increments.
  - col wraps at OUT_WIDTH-1 and increments row.
  - row wraps at OUT_WIDTH-1 and increments group.
  - Issuing the final cycle (group=NUM_GROUPS-1, row=col=OUT_WIDTH-1, k=CPP-1) moves to DRAIN.
- Issue marks go into a PIPE_LAT-deep shift register: first = (k==0), last = (k==CPP-1), plus the row/col/group tag.
  - accum_sload = first mark at depth PIPE_LAT.
  - pixel_valid = last mark delayed PIPE_LAT+1; tags travel with the mark.
- mult_en=1 in CLEAR, RUN and DRAIN except in stalled cycles.
- DRAIN holds until the shift register holds no marks and the final pixel_valid has fired.
- DONE lasts 1 cycle: done=1 and busy=0. Then -> IDLE.
- stall=1 in RUN/DRAIN freezes everything:
  - counters, shift register and FSM hold;
  - mem_rden=0, mult_en=0, accum_sload=0, pixel_valid=0;
  - mem_sel holds its value.
- stall in IDLE, CLEAR or DONE has no effect.
- Counters never exceed their terminal values. mem_sel is always < NUM_MEM.

Test Plan:
- Small config (NUM_MEM=2, KERNEL_CYCLES=3, OUT_WIDTH=2, NUM_GROUPS=1, PIPE_LAT=3), go sampled at edge t:
  - mult_clear=1 at t+1;
  - mem_rden=1 for cycles t+2..t+25 (24 cycles), with mem_sel pattern 0,0,0,1,1,1 repeating.
- Same config, sload and valid timing:
  - accum_sload pulses at t+5, t+11, t+17, t+23;
  - pixel_valid at t+11, t+17, t+23, t+29 with (row,col) = (0,0), (0,1), (1,0), (1,1);
  - done at t+30 with busy low in the same cycle.
- Same config, stall=1 for 4 cycles starting at t+7:
  - mem_rden and mult_en low for those 4 cycles;
  - all subsequent events shift by +4; done at t+34.
- go held high throughout the run: no second CLEAR until after done. A restart begins CLEAR one cycle after IDLE re-entry.
- Reset asserted at t+15 mid-RUN:
  - all outputs 0 asynchronously, no done pulse;
  - a new go then produces the exact timing of the first scenario.
- Default parameters:
  - exactly 1600 pixel_valid pulses;
  - group_idx increments every 100 pulses;
  - done fires once, PIPE_LAT+2 cycles after the last mem_rden.
